// File: rtl/ps2_key_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_key_decoder_if
//  Description : Bundle between a PS/2 byte receiver / character consumer and
//                the ps2_key_decoder.
//                  scan_code    [7:0] received PS/2 byte
//                  scan_valid         one-cycle strobe for scan_code
//                  ascii_ready        consumer pops FIFO head when valid
//                  ascii_out    [7:0] character at FIFO head (0x00 if empty)
//                  ascii_valid        FIFO non-empty
//                  overflow           sticky character-dropped flag
//                  shift_active       either Shift key held
//                  caps_active        Caps Lock toggle state
//                master = receiver/consumer side, slave = decoder side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ps2_key_decoder_if;
    logic [7:0] scan_code;
    logic       scan_valid;
    logic       ascii_ready;
    logic [7:0] ascii_out;
    logic       ascii_valid;
    logic       overflow;
    logic       shift_active;
    logic       caps_active;

    modport master (
        output scan_code, scan_valid, ascii_ready,
        input  ascii_out, ascii_valid, overflow, shift_active, caps_active
    );

    modport slave (
        input  scan_code, scan_valid, ascii_ready,
        output ascii_out, ascii_valid, overflow, shift_active, caps_active
    );
endinterface
`default_nettype wire

// File: rtl/ps2_key_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_key_decoder
//  Description : Stateful PS/2 set-2 scan-code to ASCII decoder with
//                make/break/extended prefix tracking, Shift and Caps Lock
//                state, and a FIFO_DEPTH-entry character FIFO.
//  Ports       : clk  - system clock, rising edge
//                rst  - synchronous active-high reset, clears all state
//                kbd  - ps2_key_decoder_if.slave (scan input, ASCII output,
//                       status flags)
//  Parameters  : FIFO_DEPTH - character FIFO entries, power of two, >= 2
//  Options     : PS2_REPEAT_FILTER_EN - when defined, a repeated make of the
//                same character-producing code is suppressed until its break
//                or a different make arrives.
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_key_decoder #(
    parameter int FIFO_DEPTH = 8
) (
    input  wire logic        clk,
    input  wire logic        rst,
    ps2_key_decoder_if.slave kbd
);
    localparam int                 c_PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [c_PTR_W:0]   c_FULL  = FIFO_DEPTH[c_PTR_W:0];

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_EXT     = 2'd1,
        S_BRK     = 2'd2,
        S_EXT_BRK = 2'd3
    } state_t;

    state_t               r_state;
    logic                 r_shift_l;
    logic                 r_shift_r;
    logic                 r_caps;
    logic                 r_overflow;
    logic [7:0]           r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_PTR_W:0]     r_count;

    logic [7:0]           w_letter;   // uppercase letter, 0 if not a letter
    logic [7:0]           w_char;
    logic                 w_mapped;
    logic                 w_is_make;
    logic                 w_repeat;
    logic                 w_push_req;
    logic                 w_push_ok;
    logic                 w_pop;
    logic                 w_valid;

    // ------------------------------------------------------------------
    // Scan-code lookup; case selection uses the registered modifier state
    // ------------------------------------------------------------------
    always_comb begin
        w_letter = 8'h00;
        case (kbd.scan_code)
            8'h1C: w_letter = 8'h41; 8'h32: w_letter = 8'h42; 8'h21: w_letter = 8'h43;
            8'h23: w_letter = 8'h44; 8'h24: w_letter = 8'h45; 8'h2B: w_letter = 8'h46;
            8'h34: w_letter = 8'h47; 8'h33: w_letter = 8'h48; 8'h43: w_letter = 8'h49;
            8'h3B: w_letter = 8'h4A; 8'h42: w_letter = 8'h4B; 8'h4B: w_letter = 8'h4C;
            8'h3A: w_letter = 8'h4D; 8'h31: w_letter = 8'h4E; 8'h44: w_letter = 8'h4F;
            8'h4D: w_letter = 8'h50; 8'h15: w_letter = 8'h51; 8'h2D: w_letter = 8'h52;
            8'h1B: w_letter = 8'h53; 8'h2C: w_letter = 8'h54; 8'h3C: w_letter = 8'h55;
            8'h2A: w_letter = 8'h56; 8'h1D: w_letter = 8'h57; 8'h22: w_letter = 8'h58;
            8'h35: w_letter = 8'h59; 8'h1A: w_letter = 8'h5A;
            default: w_letter = 8'h00;
        endcase
    end

    always_comb begin
        logic w_shift;
        w_shift  = r_shift_l | r_shift_r;
        w_char   = 8'h00;
        w_mapped = 1'b1;
        if (w_letter != 8'h00) begin
            // Lowercase is uppercase with bit 5 set
            w_char = (w_shift ^ r_caps) ? w_letter : (w_letter | 8'h20);
        end else begin
            case (kbd.scan_code)
                8'h45: w_char = w_shift ? 8'h29 : 8'h30;
                8'h16: w_char = w_shift ? 8'h21 : 8'h31;
                8'h1E: w_char = w_shift ? 8'h40 : 8'h32;
                8'h26: w_char = w_shift ? 8'h23 : 8'h33;
                8'h25: w_char = w_shift ? 8'h24 : 8'h34;
                8'h2E: w_char = w_shift ? 8'h25 : 8'h35;
                8'h36: w_char = w_shift ? 8'h5E : 8'h36;
                8'h3D: w_char = w_shift ? 8'h26 : 8'h37;
                8'h3E: w_char = w_shift ? 8'h2A : 8'h38;
                8'h46: w_char = w_shift ? 8'h28 : 8'h39;
                8'h29: w_char = 8'h20;
                8'h5A: w_char = 8'h0A;
                8'h66: w_char = 8'h08;
                default: w_mapped = 1'b0;
            endcase
        end
    end

    assign w_is_make  = kbd.scan_valid && (r_state == S_IDLE) &&
                        (kbd.scan_code != 8'hE0) && (kbd.scan_code != 8'hF0);
    assign w_valid    = (r_count != '0);
    assign w_pop      = w_valid && kbd.ascii_ready;
    assign w_push_req = w_is_make && w_mapped && !w_repeat;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    assign w_push_ok  = w_push_req && ((r_count != c_FULL) || w_pop);

`ifdef PS2_REPEAT_FILTER_EN
    logic [7:0] r_last_make;

    assign w_repeat = (kbd.scan_code == r_last_make);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_make <= 8'h00;
        end else if (w_is_make) begin
            // Any non-character make also ends the repeat window
            r_last_make <= w_mapped ? kbd.scan_code : 8'h00;
        end else if (kbd.scan_valid && (r_state == S_BRK) &&
                     (kbd.scan_code == r_last_make)) begin
            r_last_make <= 8'h00;
        end
    end
`else
    assign w_repeat = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Prefix FSM, modifier state and FIFO bookkeeping
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_shift_l  <= 1'b0;
            r_shift_r  <= 1'b0;
            r_caps     <= 1'b0;
            r_overflow <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            if (kbd.scan_valid) begin
                case (r_state)
                    S_IDLE: begin
                        if (kbd.scan_code == 8'hE0)      r_state <= S_EXT;
                        else if (kbd.scan_code == 8'hF0) r_state <= S_BRK;
                        else if (kbd.scan_code == 8'h12) r_shift_l <= 1'b1;
                        else if (kbd.scan_code == 8'h59) r_shift_r <= 1'b1;
                        else if (kbd.scan_code == 8'h58) r_caps <= ~r_caps;
                    end
                    S_EXT: begin
                        r_state <= (kbd.scan_code == 8'hF0) ? S_EXT_BRK : S_IDLE;
                    end
                    S_BRK: begin
                        if (kbd.scan_code == 8'h12) r_shift_l <= 1'b0;
                        if (kbd.scan_code == 8'h59) r_shift_r <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end

            if (w_push_req && !w_push_ok) r_overflow <= 1'b1;
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= w_char;
    end

    assign kbd.ascii_out    = w_valid ? r_mem[r_rd_ptr] : 8'h00;
    assign kbd.ascii_valid  = w_valid;
    assign kbd.overflow     = r_overflow;
    assign kbd.shift_active = r_shift_l | r_shift_r;
    assign kbd.caps_active  = r_caps;

endmodule
`default_nettype wire

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Stateful PS/2 set-2 keyboard decoder that turns a stream of raw scan-code bytes into ASCII characters buffered in a parametrised FIFO. It tracks make/break (0xF0) and extended (0xE0) prefixes, Shift and Caps Lock state, and emits lower/upper-case letters and shifted digit symbols. It sits between the PS/2 byte receiver and the character consumer (text buffer / processor I/O port) and supersedes the purely combinational scan-code-to-ASCII lookup.

## Interface
- FIFO_DEPTH, 8, character FIFO entries; power of two, ≥2
- clock  in  1  system clock; all logic rising-edge
- reset  in  1  synchronous, active-high; clears all state
- scan_code  in  8  received PS/2 byte
- scan_valid  in  1  one-cycle strobe, scan_code valid this cycle
- ascii_out  out  8  ASCII character at FIFO head; 0x00 when empty
- ascii_valid  out  1  FIFO non-empty
- ascii_ready  in  1  consumer pops head when ascii_valid && ascii_ready
- overflow  out  1  sticky: a character was dropped on a full FIFO; cleared only by reset
- shift_active  out  1  either Shift key (0x12, 0x59) currently held
- caps_active  out  1  Caps Lock toggle state

## Operation
- Prefix FSM, advances only on scan_valid:
  - IDLE: 0xE0→EXT; 0xF0→BRK; other byte→process as make, stay IDLE
  - EXT: 0xF0→EXT_BRK; other byte→discard (extended make), →IDLE
  - BRK: byte processed as break, →IDLE
  - EXT_BRK: byte discarded, →IDLE
- Make handling: 0x12/0x59 set left/right shift bit; 0x58 toggles caps_active; mapped key pushes a character; unmapped codes push nothing.
- Break handling: 0x12/0x59 clear corresponding shift bit; all other breaks push nothing.
- Letters (A–Z set-2 codes, e.g. 0x1C=A, 0x1A=Z): uppercase (0x41–0x5A) when shift_active XOR caps_active, else lowercase (0x61–0x7A).
- Digits 0x45,0x16,0x1E,0x26,0x25,0x2E,0x36,0x3D,0x3E,0x46: unshifted '0'–'9'; shifted ')','!','@','#','$','%','^','&','*','('. Caps Lock does not affect digits.
- Space 0x29→0x20, Enter 0x5A→0x0A, Backspace 0x66→0x08, regardless of modifiers.
- FIFO: circular buffer, read/write pointers log2(FIFO_DEPTH) bits wrapping naturally, occupancy counter log2(FIFO_DEPTH)+1 bits.
- Full: push dropped, overflow set; pointers unchanged. Full with simultaneous pop: push accepted, occupancy unchanged.
- Empty: ascii_ready ignored; ascii_out = 0x00.

## Timing
- Reset values: ascii_out 0x00, ascii_valid 0, overflow 0, shift_active 0, caps_active 0, FSM IDLE, FIFO empty.
- Latency: make byte strobed in cycle N → character visible, ascii_valid high in cycle N+1 (FIFO previously empty).
- Modifier updates visible on shift_active/caps_active in cycle N+1; a letter in the byte after the modifier uses the updated state.
- Pop: handshake in cycle N → next entry (or empty) presented in cycle N+1.
- ascii_out driven from registered FIFO state; no combinational path from scan_code/scan_valid to outputs.
- Reset mid-sequence (e.g. after 0xF0) discards the prefix, all buffered characters and modifier state.
- scan_valid low: FSM holds; prefixes do not time out.

## Configuration
- PS2_REPEAT_FILTER_EN defined: a 8-bit last-make register records the most recent character-producing make code; a repeated make of the same code (typematic repeat) pushes nothing until that code's break is received or a different make arrives. Register cleared on reset.
- Undefined: every make of a mapped key pushes a character, including typematic repeats.

## Test plan
- Reset, then 0x1C strobe → cycle later ascii_valid=1, ascii_out=0x61 ('a'); pop → ascii_valid=0, ascii_out=0x00.
- 0x12, 0x1C, 0xF0 0x12, 0x1C → FIFO yields 0x41 then 0x61; shift_active 1 then 0; break bytes push nothing.
- 0x58, 0xF0 0x58, 0x12, 0x1C, 0x16 → caps_active=1; outputs 0x61 (caps XOR shift) then 0x21 ('!').
- 0xE0 0x75, 0xE0 0xF0 0x75, 0x0E (unmapped) → no pushes, FSM back to IDLE, next 0x29 → 0x20.
- ascii_ready=0, push FIFO_DEPTH+1 chars → ascii_valid=1, overflow=1, pop yields first FIFO_DEPTH chars in order; push with simultaneous pop at full accepted.
- 0x1C ×3 without break: with PS2_REPEAT_FILTER_EN one 0x61; without, three 0x61.
